// File: rtl/bin_window_3x3.sv
// 3x3 binary window generator: two 1-bit row delays feed a sliding window, one window per
// interior pixel. Define BIN_WINDOW_XNOR_EN to add the w_in kernel and win_popcnt XNOR count.
module bin_window_3x3 #(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256,
  localparam int unsigned COL_W = $clog2(IMG_WIDTH),
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_in,
  input  logic             pix_valid,
  input  logic             sof,
`ifdef BIN_WINDOW_XNOR_EN
  input  logic [8:0]       w_in,
  output logic [3:0]       win_popcnt,
`endif
  output logic [8:0]       win_out,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done
);

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  state_e               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [IMG_WIDTH-1:0] rd0_q, rd0_d;
  logic [IMG_WIDTH-1:0] rd1_q, rd1_d;
  // Left and middle columns of each window row; the right column is formed live.
  logic [1:0]           wtop_q, wtop_d;
  logic [1:0]           wmid_q, wmid_d;
  logic [1:0]           wbot_q, wbot_d;
  logic [8:0]           win_out_q, win_out_d;
  logic                 win_valid_q, win_valid_d;
  logic [ROW_W-1:0]     win_row_q, win_row_d;
  logic [COL_W-1:0]     win_col_q, win_col_d;
  logic                 frame_done_q, frame_done_d;

  logic                 accept;
  logic [COL_W-1:0]     cur_col;
  logic [ROW_W-1:0]     cur_row;
  logic                 last_col;
  logic                 last_row;
  logic                 rd0_out;
  logic                 rd1_out;
  logic [8:0]           win_next;

`ifdef BIN_WINDOW_XNOR_EN
  logic [3:0]           popcnt_q, popcnt_d;
  logic [8:0]           match;
  logic [3:0]           popcnt_sum;

  always_comb begin
    match      = ~(win_next ^ w_in);
    popcnt_sum = '0;
    for (int i = 0; i < 9; i++) begin
      popcnt_sum = popcnt_sum + {3'b000, match[i]};
    end
  end
`endif

  // sof re-anchors the current pixel at (0,0) regardless of the running counters.
  always_comb begin
    accept   = pix_valid & ((state_q != StIdle) | sof);
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    rd0_out  = rd0_q[IMG_WIDTH-1];
    rd1_out  = rd1_q[IMG_WIDTH-1];
    win_next = {wtop_q, rd1_out, wmid_q, rd0_out, wbot_q, pix_in};
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    wtop_d       = wtop_q;
    wmid_d       = wmid_q;
    wbot_d       = wbot_q;
    win_out_d    = win_out_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef BIN_WINDOW_XNOR_EN
    popcnt_d     = popcnt_q;
`endif

    if (accept) begin
      rd0_d  = {rd0_q[IMG_WIDTH-2:0], pix_in};
      rd1_d  = {rd1_q[IMG_WIDTH-2:0], rd0_out};
      wtop_d = {wtop_q[0], rd1_out};
      wmid_d = {wmid_q[0], rd0_out};
      wbot_d = {wbot_q[0], pix_in};

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      if (sof) begin
        state_d = StFill;
      end else begin
        unique case (state_q)
          StFill: begin
            if ((cur_row == ROW_W'(1)) && last_col) state_d = StStream;
          end
          StStream: begin
            if (last_row && last_col) state_d = StIdle;
          end
          default: state_d = state_q;
        endcase
      end

      // Columns 0-1 hold leftovers from the previous row, so they never emit.
      if ((cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2))) begin
        win_valid_d  = 1'b1;
        win_out_d    = win_next;
        win_row_d    = cur_row - ROW_W'(1);
        win_col_d    = cur_col - COL_W'(1);
        frame_done_d = last_row & last_col;
`ifdef BIN_WINDOW_XNOR_EN
        popcnt_d     = popcnt_sum;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
      wtop_q       <= '0;
      wmid_q       <= '0;
      wbot_q       <= '0;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef BIN_WINDOW_XNOR_EN
      popcnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      wtop_q       <= wtop_d;
      wmid_q       <= wmid_d;
      wbot_q       <= wbot_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
`ifdef BIN_WINDOW_XNOR_EN
      popcnt_q     <= popcnt_d;
`endif
    end
  end

  assign win_out    = win_out_q;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;
`ifdef BIN_WINDOW_XNOR_EN
  assign win_popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_bin_window_3x3.sv
// Scoreboard bench for bin_window_3x3 on a 4x4 image: a frame-array model predicts every
// window and its due cycle; a negedge monitor pops and compares.
module tb_bin_window_3x3;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_in;
  logic       pix_valid;
  logic       sof;
  logic [8:0] win_out;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;
  logic       frame_done;
`ifdef BIN_WINDOW_XNOR_EN
  logic [8:0] w_in;
  logic [3:0] win_popcnt;
`endif

  bin_window_3x3 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
`ifdef BIN_WINDOW_XNOR_EN
    .w_in      (w_in),
    .win_popcnt(win_popcnt),
`endif
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] win;
    int         row;
    int         col;
    logic       fd;
    logic [3:0] pc;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   win_cnt = 0;
  int   fd_cnt = 0;

  // Reference model state: position of the next pixel and the current frame image.
  bit         m_active = 1'b0;
  int         m_row = 0;
  int         m_col = 0;
  bit         img [0:H-1][0:W-1];
  logic [8:0] m_w = 9'h000;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < edge_cnt) begin
      e = q.pop_front();
      checks++; failures++;
      $display("FAIL missed_window: no win_valid, required win=%h at (%0d,%0d)",
               e.win, e.row, e.col);
    end
    if (win_valid === 1'b1) begin
      win_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (q.size() == 0 || q[0].due != edge_cnt) begin
        checks++; failures++;
        $display("FAIL unexpected_window: got win=%h at (%0d,%0d), required none",
                 win_out, win_row, win_col);
      end else begin
        e = q.pop_front();
        checks++;
        if ({win_out, win_row, win_col, frame_done} !== {e.win, 2'(e.row), 2'(e.col), e.fd}) begin
          failures++;
          $display("FAIL window: got win=%h row=%0d col=%0d fd=%b, required win=%h row=%0d col=%0d fd=%b",
                   win_out, win_row, win_col, frame_done, e.win, e.row, e.col, e.fd);
        end
`ifdef BIN_WINDOW_XNOR_EN
        checks++;
        if (win_popcnt !== e.pc) begin
          failures++;
          $display("FAIL popcnt: got %0d, required %0d", win_popcnt, e.pc);
        end
`endif
      end
    end else begin
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        e = q.pop_front();
        checks++; failures++;
        $display("FAIL missing_window: win_valid=%b, required win=%h at (%0d,%0d)",
                 win_valid, e.win, e.row, e.col);
      end
      checks++;
      if (frame_done !== 1'b0) begin
        failures++;
        $display("FAIL frame_done_idle: got %b, required 0", frame_done);
      end
    end
  end

  task automatic model_accept(input logic p, input logic s);
    exp_t e;
    if (s) begin
      m_row = 0;
      m_col = 0;
    end
    m_active = 1'b1;
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[8 - (i * 3 + j)] = img[m_row - 2 + i][m_col - 2 + j];
      e.row = m_row - 1;
      e.col = m_col - 1;
      e.fd  = (m_row == H - 1) && (m_col == W - 1);
      e.pc  = 4'($countones(~(e.win ^ m_w)));
      e.due = edge_cnt + 1;
      q.push_back(e);
    end
    if (m_col == W - 1) begin
      m_col = 0;
      if (m_row == H - 1) begin
        m_row = 0;
        m_active = 1'b0;
      end else begin
        m_row++;
      end
    end else begin
      m_col++;
    end
  endtask

  task automatic drive(input logic p, input logic v, input logic s);
    @(negedge clk);
    pix_in    = p;
    pix_valid = v;
    sof       = s;
    if (v && (m_active || s)) model_accept(p, s);
  endtask

  task automatic send_frame(input logic [15:0] bits, input int gap_pct);
    for (int k = 0; k < W * H; k++) begin
      while (int'($urandom_range(99)) < gap_pct) drive(1'($urandom), 1'b0, 1'($urandom));
      drive(bits[k], 1'b1, k == 0);
    end
  endtask

  task automatic drain(input string name, input int exp_wins, input int w0, input int f0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_queue: %0d windows outstanding, required 0", name, q.size());
    end
    checks++;
    if (win_cnt - w0 != exp_wins || fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL %s_count: got %0d windows %0d frame_done, required %0d and 1",
               name, win_cnt - w0, fd_cnt - f0, exp_wins);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      pix_in    = 1'($urandom);
      pix_valid = 1'($urandom);
      sof       = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({win_out, win_valid, win_row, win_col, frame_done} !== 15'h0) begin
        failures++;
        $display("FAIL reset: got win=%h v=%b row=%0d col=%0d fd=%b, required all 0",
                 win_out, win_valid, win_row, win_col, frame_done);
      end
    end
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst       = 1'b1;
    m_active  = 1'b0;
  endtask

  task automatic test_all_ones();
    int w0 = win_cnt, f0 = fd_cnt;
    send_frame(16'hFFFF, 0);
    drain("all_ones", 4, w0, f0);
  endtask

  task automatic test_single_one();
    int w0 = win_cnt, f0 = fd_cnt;
    send_frame(16'h0400, 0);
    drain("single_one", 4, w0, f0);
  endtask

  task automatic test_gaps();
    int w0 = win_cnt, f0 = fd_cnt;
    repeat (5) drive(1'b1, 1'b1, 1'b0);
    send_frame(16'h0400, 40);
    drain("gaps", 4, w0, f0);
  endtask

  task automatic test_restart();
    int w0 = win_cnt, f0 = fd_cnt;
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, k == 0);
    send_frame(16'h0000, 0);
    drain("restart", 4, w0, f0);
  endtask

  task automatic test_reset_mid();
    int w0, f0;
`ifdef BIN_WINDOW_XNOR_EN
    w_in = 9'h0F0;
    m_w  = 9'h0F0;
`endif
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, k == 0);
    @(negedge clk);
    rst       = 1'b0;
    pix_valid = 1'b1;
    sof       = 1'b0;
    m_active  = 1'b0;
    @(negedge clk);
    checks++;
    if ({win_out, win_valid, win_row, win_col, frame_done} !== 15'h0) begin
      failures++;
      $display("FAIL reset_mid: got win=%h v=%b row=%0d col=%0d fd=%b, required all 0",
               win_out, win_valid, win_row, win_col, frame_done);
    end
    rst = 1'b1;
    w0  = win_cnt;
    f0  = fd_cnt;
    repeat (6) drive(1'b1, 1'b1, 1'b0);
    send_frame(16'hFFFF, 0);
    drain("reset_mid", 4, w0, f0);
  endtask

  initial begin
    rst       = 1'b0;
    pix_in    = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
`ifdef BIN_WINDOW_XNOR_EN
    w_in      = 9'h000;
`endif
    test_reset();
    test_all_ones();
    test_single_one();
    test_gaps();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_window_3x3.md
Name: bin_window_3x3

Overview:
Downstream consumer of the 1-bit line-delay stage in the binary image path. It takes a raster-order stream of binary pixels and keeps two row delays of IMG_WIDTH bits, gated by pixel-valid. It builds a 3x3 bit window and emits one window per valid ("no padding") output position, with centre coordinates and an end-of-frame pulse. It feeds the binary convolution / XNOR stages.

Parameters:
IMG_WIDTH, 256, pixels per row; also the depth of each internal row delay; minimum 3.
IMG_HEIGHT, 256, rows per frame; minimum 3.
COL_W, $clog2(IMG_WIDTH), column counter / coordinate width (derived, not overridden).
ROW_W, $clog2(IMG_HEIGHT), row counter / coordinate width (derived, not overridden).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
pix_in  input  1  binary pixel, raster order
pix_valid  input  1  pix_in accepted this cycle when high
sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0)
win_out  output  9  3x3 window; bit8=top-left, bit7=top-mid, bit6=top-right, bit5=mid-left, bit4=centre, bit3=mid-right, bit2=bot-left, bit1=bot-mid, bit0=bot-right
win_valid  output  1  win_out/win_row/win_col valid this cycle
win_row  output  ROW_W  window centre row
win_col  output  COL_W  window centre column
frame_done  output  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset: rst=0 at a clock edge clears both row delays, window registers, counters, win_out, win_valid, win_row, win_col and frame_done to 0. State goes to IDLE. Reset mid-frame abandons the frame.
- Accept: a pixel is accepted only when pix_valid=1 and the state is not IDLE, or when pix_valid=1 and sof=1 in any state.
- On an accept cycle:
  - Row delays shift by one. Row delay 0 takes pix_in. Row delay 1 takes the output of row delay 0.
  - Each window row shifts left by one column. The new right column is {row delay 1 out, row delay 0 out, pix_in} for the top/mid/bottom rows.
- With pix_valid=0, all state holds and win_valid=0.
- Counters: col increments 0..IMG_WIDTH-1 and then wraps to 0 while row increments. row runs 0..IMG_HEIGHT-1.
- sof=1 with pix_valid=1 in any state forces this pixel to (0,0) and restarts the counters.
  - Row-delay contents are not cleared. Stale data is masked by the valid rule below.
- States:
  - IDLE: waits for sof & pix_valid, then goes to FILL.
  - FILL: rows 0-1 are accepted; no windows are produced. At the end of row 1 it goes to STREAM.
  - STREAM: rows 2..IMG_HEIGHT-1. Accepting the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) returns to IDLE.
- Output rule: accepting pixel (r,c) with r>=2 and c>=2 causes, registered at the next edge (latency 1):
  - win_valid=1
  - win_row=r-1, win_col=c-1
  - win_out = pixels rows r-2..r, cols c-2..c
- Columns 0-1 never raise win_valid, so window columns left over from the previous row are never emitted.
- Windows per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- frame_done=1 in the same cycle as the win_valid for centre (IMG_HEIGHT-2, IMG_WIDTH-2); otherwise 0.
- pix_valid without sof in IDLE: the pixel is dropped and nothing changes.
- Outputs hold their last values when win_valid=0, except frame_done, which is 0.

Optional Feature:
BIN_WINDOW_XNOR_EN
- Defined:
  - Adds input w_in (9 bits, weight kernel, same bit order as win_out).
  - Adds output win_popcnt (4 bits) = number of ones in (window XNOR w_in).
  - win_popcnt is registered in the same cycle as win_out (no extra latency) and resets to 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4.
1. Hold rst=0 for 3 cycles with random inputs -> win_out=0, win_valid=0, win_row=0, win_col=0, frame_done=0 every cycle.
2. All-ones frame with sof on the first pixel and pix_valid continuous -> exactly 4 windows, win_out=9'h1FF, centres (1,1),(1,2),(2,1),(2,2), each 1 cycle after accepting (2,2),(2,3),(3,2),(3,3); frame_done with the 4th only.
3. Zero frame with a single 1 at (2,2) -> windows 9'h001 @(1,1), 9'h002 @(1,2), 9'h008 @(2,1), 9'h010 @(2,2).
4. Scenario 3 with pix_valid randomly deasserted (~40%) and pixels sent before sof -> identical window sequence; pre-sof pixels have no effect.
5. Start an all-ones frame, assert sof again on the 7th pixel, then send a full zero frame -> no windows from the aborted frame; 4 windows of 9'h000, frame_done once.
6. Drive rst=0 for one cycle after accepting pixel (2,3) of scenario 2 -> all outputs 0 the next cycle; pixels ignored until sof; the following full frame yields 4 correct windows. With BIN_WINDOW_XNOR_EN and w_in=9'h0F0 on the all-ones frame -> win_popcnt=4.
